max_pool: RTL and testbench



---
 rtl/max_pool.sv | 106 ++++++++++
 tb/tb_max_pool.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/max_pool.sv
// Streaming signed max-pooling unit: emits the maximum of each consecutive
// window of samples accepted on running cycles, after an optional start delay.
module max_pool #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  input  logic [CNT_W-1:0]  windowSize,
  input  logic [CNT_W-1:0]  delay0,
  output logic [DATA_W-1:0] out0,
  output logic              out0_valid,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] ACC   = 2'd2;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]  delay_cnt_q, delay_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] out0_d;
  logic              out0_valid_d;
  logic [DATA_W-1:0] max_c;

  // Signed maximum of the running accumulator and the current sample.
  always_comb begin
    max_c = acc_q;
    if ($signed(in0) > $signed(acc_q)) begin
      max_c = in0;
    end
  end

  // Next-state and datapath update; run restarts from any state.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    delay_cnt_d  = delay_cnt_q;
    count_d      = count_q;
    acc_d        = acc_q;
    out0_d       = out0;
    out0_valid_d = 1'b0;

    if (run) begin
      win_d       = (windowSize == '0) ? CNT_W'(1) : windowSize;
      delay_cnt_d = delay0;
      count_d     = '0;
      acc_d       = MOST_NEG;
      state_d     = (delay0 != '0) ? DELAY : ACC;
    end else if (running) begin
      case (state_q)
        DELAY: begin
          delay_cnt_d = delay_cnt_q - CNT_W'(1);
          if (delay_cnt_q == CNT_W'(1)) begin
            state_d = ACC;
          end
        end
        ACC: begin
          if (count_q == win_q - CNT_W'(1)) begin
            out0_d       = max_c;
            out0_valid_d = 1'b1;
            acc_d        = MOST_NEG;
            count_d      = '0;
          end else begin
            acc_d   = max_c;
            count_d = count_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= CNT_W'(1);
      delay_cnt_q <= '0;
      count_q     <= '0;
      acc_q       <= MOST_NEG;
      out0        <= '0;
      out0_valid  <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      delay_cnt_q <= delay_cnt_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      out0        <= out0_d;
      out0_valid  <= out0_valid_d;
    end
  end

  assign done = (state_q != DELAY);

endmodule

// File: tb/tb_max_pool.sv
// Directed bench for max_pool with a queue-based scoreboard and output monitor.
`timescale 1ns/1ps
module tb_max_pool;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              running = 1'b0;
  logic              run = 1'b0;
  logic [DATA_W-1:0] in0 = '0;
  logic [CNT_W-1:0]  window_size = '0;
  logic [CNT_W-1:0]  delay0 = '0;
  logic [DATA_W-1:0] out0;
  logic              out0_valid;
  logic              done;

  logic [DATA_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  max_pool #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run), .in0(in0),
    .windowSize(window_size), .delay0(delay0),
    .out0(out0), .out0_valid(out0_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int ws, input int d);
    run = 1'b1;
    running = 1'b1;
    window_size = CNT_W'(ws);
    delay0 = CNT_W'(d);
    in0 = 32'h5555_5555;
    tick();
    run = 1'b0;
  endtask

  task automatic feed(input logic [31:0] v);
    in0 = v;
    running = 1'b1;
    tick();
  endtask

  task automatic stall();
    in0 = 32'h7FFF_0000;
    running = 1'b0;
    tick();
    running = 1'b1;
  endtask

  // Monitor: every valid strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (out0_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got out0=%h with no result expected", out0);
      end else begin
        check("out0", out0, exp_q.pop_front());
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("reset_out0", out0, 32'h0);
    check("reset_valid", 32'(out0_valid), 32'h0);
    check("reset_done", 32'(done), 32'h1);
    rst = 1'b0;
    feed(32'h100);
    feed(32'h200);

    // Basic window of 4.
    start(4, 0);
    check("acc_done", 32'(done), 32'h1);
    feed(3); feed(9); feed(1);
    exp_q.push_back(32'd9); feed(2);
    feed(7); feed(7); feed(0);
    exp_q.push_back(32'd7); feed(5);

    // Signed compare.
    start(2, 0);
    feed(32'h8000_0000);
    exp_q.push_back(32'hFFFF_FFFF); feed(32'hFFFF_FFFF);
    feed(32'h7FFF_FFFF);
    exp_q.push_back(32'h7FFF_FFFF); feed(32'h8000_0000);

    // Delay then stalls mid-window.
    start(2, 3);
    check("delay_done0", 32'(done), 32'h0); feed(32'h7000_0000);
    check("delay_done1", 32'(done), 32'h0); feed(32'h7000_0001);
    check("delay_done2", 32'(done), 32'h0); feed(32'h7000_0002);
    check("delay_done3", 32'(done), 32'h1);
    feed(5);
    stall();
    exp_q.push_back(32'd6); feed(6);
    feed(8);
    stall();
    stall();
    exp_q.push_back(32'd8); feed(2);

    // windowSize 0 and 1 echo every sample.
    start(0, 0);
    exp_q.push_back(32'd11); feed(11);
    exp_q.push_back(32'hFFFF_FFFD); feed(32'hFFFF_FFFD);
    stall();
    exp_q.push_back(32'd0); feed(0);
    start(1, 0);
    exp_q.push_back(32'd42); feed(42);
    exp_q.push_back(32'd7); feed(7);

    // Restart discards the partial window.
    start(4, 0);
    feed(10); feed(20); feed(30);
    start(4, 0);
    feed(1); feed(2); feed(3);
    exp_q.push_back(32'd4); feed(4);

    // Reset mid-window.
    start(4, 0);
    feed(50); feed(60);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_out0", out0, 32'h0);
    check("rst_mid_valid", 32'(out0_valid), 32'h0);
    check("rst_mid_done", 32'(done), 32'h1);
    feed(70); feed(80); feed(90); feed(100); feed(110);
    check("idle_out0", out0, 32'h0);

    // Maximum window length.
    start(65535, 0);
    for (int i = 0; i < 65535; i++) begin
      if (i == 65534) exp_q.push_back(32'h1234_5678);
      feed((i == 1000) ? 32'h1234_5678 : 32'(i));
    end
    running = 1'b0;
    tick();
    tick();
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
